// File: rtl/rand_fetch_if.sv
// Bundle of the generator request handshake and the downstream valid/ready
// stream used by rand_fetch. The master side is the fetch controller.
interface rand_fetch_if #(
    parameter int unsigned WIDTH = 8
);
    // Generator controller side
    logic             gen_start;
    logic             gen_done;
    logic [WIDTH-1:0] gen_data;

    // Consumer side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output gen_start,
        input  gen_done,
        input  gen_data,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
        input  gen_start,
        output gen_done,
        output gen_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/rand_fetch.sv
// Requester for the LFSR generator: issues start pulses, waits for done,
// captures each word into a small prefetch FIFO and streams it out over
// valid/ready. A watchdog abandons a request that never answers, sets a
// sticky error flag and lets the FSM retry from IDLE.
module rand_fetch #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    rand_fetch_if.master            bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT);

    localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic              err_q, err_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;

    logic              push;
    logic              pop;
    logic              not_empty;
    logic              has_room;

    assign not_empty = (count_q != '0);
    assign has_room  = (count_q < Full);

    // A push only ever comes from WAIT; a pop needs a held word and a ready consumer.
    assign pop = not_empty && bus.out_ready;

    //------------------------------------------------------------------
    // Request FSM
    //------------------------------------------------------------------

    // State, watchdog timer and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // Next state: one request in flight at most, new requests only from IDLE.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q;
        push    = 1'b0;

        case (state_q)
            StIdle: begin
                // Room is checked here, so the capture in WAIT can never overflow.
                if (en && has_room) begin
                    state_d = StReq;
                end
            end

            StReq: begin
                state_d = StWait;
            end

            StWait: begin
                if (bus.gen_done) begin
                    push    = 1'b1;
                    timer_d = '0;
                    state_d = StIdle;
                end else if (timer_q == TmrLast) begin
                    // Generator never answered: flag it and retry from IDLE.
                    err_d   = 1'b1;
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // Start pulse is a pure decode of registered state, so it is glitch-free.
    assign bus.gen_start = (state_q == StReq);

    //------------------------------------------------------------------
    // Prefetch FIFO
    //------------------------------------------------------------------

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.gen_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Head word is read straight from storage; a fresh push shows up a cycle later.
    assign bus.out_valid = not_empty;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign count         = count_q;
    assign err           = err_q;

    //------------------------------------------------------------------
    // Structural invariants
    //------------------------------------------------------------------
`ifndef SYNTHESIS
    // A capture always has room because requests are gated on occupancy.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> has_room);

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= Full);

    a_start_single: assert property (@(posedge clk) disable iff (rst)
        bus.gen_start |=> !bus.gen_start);

    a_timer_bound: assert property (@(posedge clk) disable iff (rst)
        timer_q <= TmrLast);
`endif

endmodule

// File: tb/tb_rand_fetch.sv
// Scoreboard bench for rand_fetch: a generator model answers start pulses,
// every word it hands over is queued, and each popped word is compared
// against the queue head. Directed phases cover fill, single pop, streaming,
// push+pop, watchdog timeout and reset mid-request.
module tb_rand_fetch;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [$clog2(DEPTH):0] count;
    logic                   err;

    rand_fetch_if #(.WIDTH(WIDTH)) bus ();

    rand_fetch #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .bus  (bus),
        .count(count),
        .err  (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Generator model: answers lat cycles after a start unless muted.
    int   lat = 5;
    bit   mute = 1'b0;
    int   inj_req = 0;
    int   inj_ack = 0;
    bit   gen_valid;
    logic [WIDTH-1:0] seeds [4] = '{8'h3A, 8'h7F, 8'h01, 8'hC4};

    initial begin : gen_model
        int rem;
        int idx;
        bit pend;
        rem = 0;
        idx = 0;
        pend = 1'b0;
        bus.gen_done = 1'b0;
        bus.gen_data = '0;
        gen_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.gen_done = 1'b0;
            gen_valid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else if (pend) begin
                rem--;
                if (rem == 0) begin
                    pend = 1'b0;
                    bus.gen_done = 1'b1;
                    gen_valid = 1'b1;
                    if (idx < 4) begin
                        bus.gen_data = seeds[idx];
                        idx++;
                    end else begin
                        bus.gen_data = WIDTH'($urandom_range(0, 255));
                    end
                end
            end
            // Stray done that the DUT must ignore; not a scoreboard entry.
            if (inj_req != inj_ack) begin
                inj_ack = inj_req;
                bus.gen_done = 1'b1;
                bus.gen_data = 8'hEE;
                gen_valid = 1'b0;
            end
            if (bus.gen_start && !mute && !rst) begin
                pend = 1'b1;
                rem = lat;
            end
        end
    end

    // Monitor: scoreboard, occupancy tracking and start-pulse bookkeeping.
    logic [WIDTH-1:0] sb_q[$];
    int   starts = 0;
    int   last_start = -1;
    int   pops = 0;
    int   max_cnt = 0;
    bit   track = 1'b0;

    initial begin : monitor
        bit   pend_push;
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
            end else begin
                pend_push = bus.gen_done && gen_valid;
                if (pend_push) sb_q.push_back(bus.gen_data);
                check_val("count_track", 32'(count), 32'(sb_q.size() - int'(pend_push)));
                check_val("valid_track", 32'(bus.out_valid),
                          32'((sb_q.size() - int'(pend_push)) != 0));
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_val("pop_unexpected", 32'(bus.out_data), 32'hFFFF_FFFF);
                    end else begin
                        check_val("pop_data", 32'(bus.out_data), 32'(sb_q[0]));
                        void'(sb_q.pop_front());
                        pops++;
                    end
                end
                if (bus.gen_start) begin
                    check_val("start_one_cycle", 32'(prev_start), 32'd0);
                    starts++;
                    last_start = cyc;
                end
            end
            prev_start = bus.gen_start;
            if (!track) max_cnt = 0;
            else if (int'(count) > max_cnt) max_cnt = int'(count);
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        int s;
        int p;
        int s0;
        int i;
        rst = 1'b1;
        en = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        sample();
        check_val("rst_gen_start", 32'(bus.gen_start), 32'd0);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_data", 32'(bus.out_data), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);

        // Fill: four answers, then no fifth request while the FIFO is full
        drive_edge();
        rst = 1'b0;
        en = 1'b1;
        for (i = 0; i < 200 && count != 4; i++) sample();
        check_val("fill_count", 32'(count), 32'd4);
        repeat (30) sample();
        check_val("fill_starts", 32'(starts), 32'd4);
        check_val("fill_head", 32'(bus.out_data), 32'h3A);

        // Single pop from full: next head shows, restart two cycles later
        drive_edge();
        bus.out_ready = 1'b1;
        p = cyc;
        s0 = starts;
        drive_edge();
        bus.out_ready = 1'b0;
        sample();
        check_val("pop1_data", 32'(bus.out_data), 32'h7F);
        check_val("pop1_count", 32'(count), 32'd3);
        for (i = 0; i < 20 && starts == s0; i++) sample();
        check_val("pop1_restart_cyc", 32'(last_start), 32'(p + 2));
        for (i = 0; i < 40 && count != 4; i++) sample();
        check_val("refill_count", 32'(count), 32'd4);

        // Streaming with ready held high: occupancy stays at or below one
        drive_edge();
        lat = 3;
        bus.out_ready = 1'b1;
        repeat (10) sample();
        track = 1'b1;
        s0 = pops;
        for (i = 0; i < 300 && pops < s0 + 12; i++) sample();
        check_val("stream_pops", 32'(pops >= s0 + 12), 32'd1);
        check_val("stream_max_le1", 32'(max_cnt <= 1), 32'd1);
        track = 1'b0;

        // Push and pop in the same cycle at count 2
        drive_edge();
        bus.out_ready = 1'b0;
        for (i = 0; i < 100 && !(count == 2 && bus.gen_start); i++) sample();
        check_val("pp_setup", 32'(count == 2 && bus.gen_start), 32'd1);
        s = cyc;
        drive_edge();
        en = 1'b0;
        drive_edge();
        drive_edge();
        bus.out_ready = 1'b1;
        sample();
        check_val("pp_done_cyc", 32'(cyc), 32'(s + 3));
        check_val("pp_count_same", 32'(count), 32'd2);
        drive_edge();
        bus.out_ready = 1'b0;
        sample();
        check_val("pp_count_after", 32'(count), 32'd2);
        drive_edge();
        bus.out_ready = 1'b1;
        repeat (4) sample();
        check_val("drain_count", 32'(count), 32'd0);
        drive_edge();
        bus.out_ready = 1'b0;

        // Watchdog timeout, retry, late done ignored
        mute = 1'b1;
        en = 1'b1;
        s0 = starts;
        for (i = 0; i < 10 && starts == s0; i++) sample();
        s = last_start;
        for (i = 0; i < 40 && err != 1'b1; i++) sample();
        check_val("to_err_cyc", 32'(cyc), 32'(s + 17));
        s0 = starts;
        for (i = 0; i < 10 && starts == s0; i++) sample();
        check_val("to_retry_cyc", 32'(last_start), 32'(s + 18));
        drive_edge();
        en = 1'b0;
        while (cyc < s + 40) drive_edge();
        s0 = starts;
        inj_req++;
        sample();
        sample();
        check_val("late_count", 32'(count), 32'd0);
        check_val("late_valid", 32'(bus.out_valid), 32'd0);
        check_val("late_err_sticky", 32'(err), 32'd1);
        check_val("late_no_start", 32'(starts), 32'(s0));

        // Reset while waiting with two words held
        drive_edge();
        mute = 1'b0;
        lat = 5;
        en = 1'b1;
        for (i = 0; i < 100 && !(count == 2 && bus.gen_start); i++) sample();
        check_val("rw_setup", 32'(count == 2 && bus.gen_start), 32'd1);
        drive_edge();
        drive_edge();
        rst = 1'b1;
        en = 1'b0;
        drive_edge();
        rst = 1'b0;
        inj_req++;
        sample();
        check_val("rw_count", 32'(count), 32'd0);
        check_val("rw_valid", 32'(bus.out_valid), 32'd0);
        check_val("rw_data", 32'(bus.out_data), 32'd0);
        check_val("rw_err", 32'(err), 32'd0);
        check_val("rw_start", 32'(bus.gen_start), 32'd0);
        sample();
        check_val("rw_no_push", 32'(count), 32'd0);
        s0 = starts;
        repeat (5) sample();
        check_val("rw_hold", 32'(starts), 32'(s0));
        drive_edge();
        en = 1'b1;
        for (i = 0; i < 10 && starts == s0; i++) sample();
        check_val("rw_resume", 32'(starts), 32'(s0 + 1));
        for (i = 0; i < 20 && count != 1; i++) sample();
        check_val("rw_first_word", 32'(count), 32'd1);

        drive_edge();
        en = 1'b0;
        repeat (10) sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
